issue_scoreboard: RTL and testbench

In-order, 4-wide issue stage sitting directly upstream of the register file read stage. It holds one decoded group of up to four instructions and releases the longest hazard-free prefix each cycle onto the register file's four input lanes. A 15-entry busy scoreboard for r1–r15 is set on issue and cleared by the four writeback ports that also feed the register file. A saturating stall counter is exposed for performance monitoring.

---
 rtl/core_pkg.sv | 32 +++
 rtl/scoreboard_bits.sv | 44 ++++
 rtl/issue_scoreboard.sv | 242 ++++++++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types, opcode constants and slot record for the issue stage
package core_pkg;

    typedef logic [3:0] reg_id_t;
    typedef logic [3:0] op_t;

    localparam op_t OP_ONE_SRC_A = 4'b0100;
    localparam op_t OP_ONE_SRC_B = 4'b0010;

    localparam int NUM_LANES = 4;

    // Slot records carry branch/immediate at a fixed upper width so the struct
    // can live here; the issue stage zero-extends on capture and truncates on output.
    localparam int BR_W_MAX  = 32;
    localparam int IME_W_MAX = 32;

    // Single-source opcodes carry junk in s2, so it must not create a hazard
    function automatic logic uses_s2(op_t op);
        return (op != OP_ONE_SRC_A) && (op != OP_ONE_SRC_B);
    endfunction

    typedef struct packed {
        logic                 vld;
        op_t                  op;
        reg_id_t              s1;
        reg_id_t              s2;
        reg_id_t              des;
        logic [BR_W_MAX-1:0]  branch;
        logic [IME_W_MAX-1:0] ime;
    } slot_t;

endpackage

// File: rtl/scoreboard_bits.sv
// rtl/scoreboard_bits.sv - busy flags for r1..r15 with set-wins set/clear ports
import core_pkg::*;

module scoreboard_bits (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  set_vld,
    input  reg_id_t     set_reg [4],
    input  logic [3:0]  clr_vld,
    input  reg_id_t     clr_reg [4],
    output logic [15:0] busy
);

    logic [15:1] busy_q;
    logic [15:1] busy_d;

    // Apply retires first, then issues, so an issue to the same register wins
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < 4; i++) begin
            if (clr_vld[i] && (clr_reg[i] != 4'd0)) begin
                busy_d[clr_reg[i]] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (set_vld[i] && (set_reg[i] != 4'd0)) begin
                busy_d[set_reg[i]] = 1'b1;
            end
        end
    end

    // Busy flop bank
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // r0 is never busy
    assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order 4-wide issue buffer with busy scoreboard and stall counter
import core_pkg::*;

module issue_scoreboard #(
    parameter int IME_W = 16,
    parameter int BR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grp_valid,
    output logic             grp_ready,
    input  logic             grp_1_vld,
    input  logic [3:0]       grp_1_op,
    input  logic [3:0]       grp_1_s1,
    input  logic [3:0]       grp_1_s2,
    input  logic [3:0]       grp_1_des,
    input  logic [BR_W-1:0]  grp_1_branch,
    input  logic [IME_W-1:0] grp_1_ime,
    input  logic             grp_2_vld,
    input  logic [3:0]       grp_2_op,
    input  logic [3:0]       grp_2_s1,
    input  logic [3:0]       grp_2_s2,
    input  logic [3:0]       grp_2_des,
    input  logic [BR_W-1:0]  grp_2_branch,
    input  logic [IME_W-1:0] grp_2_ime,
    input  logic             grp_3_vld,
    input  logic [3:0]       grp_3_op,
    input  logic [3:0]       grp_3_s1,
    input  logic [3:0]       grp_3_s2,
    input  logic [3:0]       grp_3_des,
    input  logic [BR_W-1:0]  grp_3_branch,
    input  logic [IME_W-1:0] grp_3_ime,
    input  logic             grp_4_vld,
    input  logic [3:0]       grp_4_op,
    input  logic [3:0]       grp_4_s1,
    input  logic [3:0]       grp_4_s2,
    input  logic [3:0]       grp_4_des,
    input  logic [BR_W-1:0]  grp_4_branch,
    input  logic [IME_W-1:0] grp_4_ime,
    input  logic             back_1_vld,
    input  logic [3:0]       back_1_des,
    input  logic             back_2_vld,
    input  logic [3:0]       back_2_des,
    input  logic             back_3_vld,
    input  logic [3:0]       back_3_des,
    input  logic             back_4_vld,
    input  logic [3:0]       back_4_des,
    input  logic             flush,
    output logic             iss_1_vld,
    output logic [3:0]       iss_1_op,
    output logic [3:0]       iss_1_s1,
    output logic [3:0]       iss_1_s2,
    output logic [3:0]       iss_1_des,
    output logic [BR_W-1:0]  iss_1_branch,
    output logic [IME_W-1:0] iss_1_ime,
    output logic             iss_2_vld,
    output logic [3:0]       iss_2_op,
    output logic [3:0]       iss_2_s1,
    output logic [3:0]       iss_2_s2,
    output logic [3:0]       iss_2_des,
    output logic [BR_W-1:0]  iss_2_branch,
    output logic [IME_W-1:0] iss_2_ime,
    output logic             iss_3_vld,
    output logic [3:0]       iss_3_op,
    output logic [3:0]       iss_3_s1,
    output logic [3:0]       iss_3_s2,
    output logic [3:0]       iss_3_des,
    output logic [BR_W-1:0]  iss_3_branch,
    output logic [IME_W-1:0] iss_3_ime,
    output logic             iss_4_vld,
    output logic [3:0]       iss_4_op,
    output logic [3:0]       iss_4_s1,
    output logic [3:0]       iss_4_s2,
    output logic [3:0]       iss_4_des,
    output logic [BR_W-1:0]  iss_4_branch,
    output logic [IME_W-1:0] iss_4_ime,
    output logic [15:0]      stall_cnt
);

    slot_t       grp_slot [4];
    slot_t       buf_q    [4];   // buf_q[k].vld doubles as the pending bit
    slot_t       iss_q    [4];
    logic [3:0]  pend;
    logic [3:0]  issuable;
    logic [3:0]  issue;
    logic        blocked;
    logic        haz;
    logic        accept;
    logic [15:0] busy;
    logic [15:0] claimed;
    logic [15:0] conf;
    logic [3:0]  back_vld;
    reg_id_t     back_des [4];
    reg_id_t     set_reg  [4];
    logic [3:0]  unused_hi;

    // Gather the flat per-slot ports into slot records
    always_comb begin
        grp_slot[0] = '{vld: grp_1_vld, op: grp_1_op, s1: grp_1_s1, s2: grp_1_s2, des: grp_1_des,
                        branch: BR_W_MAX'(grp_1_branch), ime: IME_W_MAX'(grp_1_ime)};
        grp_slot[1] = '{vld: grp_2_vld, op: grp_2_op, s1: grp_2_s1, s2: grp_2_s2, des: grp_2_des,
                        branch: BR_W_MAX'(grp_2_branch), ime: IME_W_MAX'(grp_2_ime)};
        grp_slot[2] = '{vld: grp_3_vld, op: grp_3_op, s1: grp_3_s1, s2: grp_3_s2, des: grp_3_des,
                        branch: BR_W_MAX'(grp_3_branch), ime: IME_W_MAX'(grp_3_ime)};
        grp_slot[3] = '{vld: grp_4_vld, op: grp_4_op, s1: grp_4_s1, s2: grp_4_s2, des: grp_4_des,
                        branch: BR_W_MAX'(grp_4_branch), ime: IME_W_MAX'(grp_4_ime)};
        back_vld    = {back_4_vld, back_3_vld, back_2_vld, back_1_vld};
        back_des[0] = back_1_des;
        back_des[1] = back_2_des;
        back_des[2] = back_3_des;
        back_des[3] = back_4_des;
        for (int k = 0; k < 4; k++) begin
            pend[k]    = buf_q[k].vld;
            set_reg[k] = buf_q[k].des;
        end
    end

    // Longest hazard-free prefix of pending slots; earlier pending slots claim their dest
    always_comb begin
        issuable = '0;
        blocked  = 1'b0;
        claimed  = '0;
        conf     = '0;
        haz      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (buf_q[k].vld) begin
                conf = busy | claimed;
                haz  = conf[buf_q[k].s1]
                     | (uses_s2(buf_q[k].op) & conf[buf_q[k].s2])
                     | conf[buf_q[k].des];
                if (!blocked && !haz) begin
                    issuable[k] = 1'b1;
                    if (buf_q[k].des != 4'd0) begin
                        claimed[buf_q[k].des] = 1'b1;
                    end
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    assign issue     = flush ? 4'b0000 : issuable;
    assign grp_ready = !flush && !blocked;
    assign accept    = grp_valid && grp_ready;

    scoreboard_bits u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_vld (issue),
        .set_reg (set_reg),
        .clr_vld (back_vld),
        .clr_reg (back_des),
        .busy    (busy)
    );

    // Group buffer: flush drops everything, accept reloads, issue clears pending
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[k].vld <= 1'b0;
            end
        end else if (accept) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= grp_slot[k];
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (issue[k]) begin
                    buf_q[k].vld <= 1'b0;
                end
            end
        end
    end

    // Issue registers: load on issue, otherwise drop vld and hold fields
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                iss_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (issue[k]) begin
                    iss_q[k] <= buf_q[k];
                end else begin
                    iss_q[k].vld <= 1'b0;
                end
            end
        end
    end

    // Saturating count of cycles with work pending but nothing leaving
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((|pend) && (issue == 4'b0000) && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Upper bits of the widened branch/immediate fields are always zero
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            unused_hi[k] = (^(iss_q[k].branch >> BR_W)) ^ (^(iss_q[k].ime >> IME_W));
        end
    end

    assign iss_1_vld    = iss_q[0].vld;
    assign iss_1_op     = iss_q[0].op;
    assign iss_1_s1     = iss_q[0].s1;
    assign iss_1_s2     = iss_q[0].s2;
    assign iss_1_des    = iss_q[0].des;
    assign iss_1_branch = iss_q[0].branch[BR_W-1:0];
    assign iss_1_ime    = iss_q[0].ime[IME_W-1:0];
    assign iss_2_vld    = iss_q[1].vld;
    assign iss_2_op     = iss_q[1].op;
    assign iss_2_s1     = iss_q[1].s1;
    assign iss_2_s2     = iss_q[1].s2;
    assign iss_2_des    = iss_q[1].des;
    assign iss_2_branch = iss_q[1].branch[BR_W-1:0];
    assign iss_2_ime    = iss_q[1].ime[IME_W-1:0];
    assign iss_3_vld    = iss_q[2].vld;
    assign iss_3_op     = iss_q[2].op;
    assign iss_3_s1     = iss_q[2].s1;
    assign iss_3_s2     = iss_q[2].s2;
    assign iss_3_des    = iss_q[2].des;
    assign iss_3_branch = iss_q[2].branch[BR_W-1:0];
    assign iss_3_ime    = iss_q[2].ime[IME_W-1:0];
    assign iss_4_vld    = iss_q[3].vld;
    assign iss_4_op     = iss_q[3].op;
    assign iss_4_s1     = iss_q[3].s1;
    assign iss_4_s2     = iss_q[3].s2;
    assign iss_4_des    = iss_q[3].des;
    assign iss_4_branch = iss_q[3].branch[BR_W-1:0];
    assign iss_4_ime    = iss_q[3].ime[IME_W-1:0];

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed bench with a behavioural issue model for issue_scoreboard
module tb_issue_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        grp_valid;
    logic        flush;
    wire         grp_ready;
    logic        g_vld [4];
    logic [3:0]  g_op  [4];
    logic [3:0]  g_s1  [4];
    logic [3:0]  g_s2  [4];
    logic [3:0]  g_des [4];
    logic [3:0]  g_br  [4];
    logic [15:0] g_ime [4];
    logic        b_vld [4];
    logic [3:0]  b_des [4];
    wire         o_vld [4];
    wire  [3:0]  o_op  [4];
    wire  [3:0]  o_s1  [4];
    wire  [3:0]  o_s2  [4];
    wire  [3:0]  o_des [4];
    wire  [3:0]  o_br  [4];
    wire  [15:0] o_ime [4];
    wire  [15:0] stall_cnt;

    issue_scoreboard dut (
        .clk(clk), .rst(rst), .grp_valid(grp_valid), .grp_ready(grp_ready),
        .grp_1_vld(g_vld[0]), .grp_1_op(g_op[0]), .grp_1_s1(g_s1[0]), .grp_1_s2(g_s2[0]),
        .grp_1_des(g_des[0]), .grp_1_branch(g_br[0]), .grp_1_ime(g_ime[0]),
        .grp_2_vld(g_vld[1]), .grp_2_op(g_op[1]), .grp_2_s1(g_s1[1]), .grp_2_s2(g_s2[1]),
        .grp_2_des(g_des[1]), .grp_2_branch(g_br[1]), .grp_2_ime(g_ime[1]),
        .grp_3_vld(g_vld[2]), .grp_3_op(g_op[2]), .grp_3_s1(g_s1[2]), .grp_3_s2(g_s2[2]),
        .grp_3_des(g_des[2]), .grp_3_branch(g_br[2]), .grp_3_ime(g_ime[2]),
        .grp_4_vld(g_vld[3]), .grp_4_op(g_op[3]), .grp_4_s1(g_s1[3]), .grp_4_s2(g_s2[3]),
        .grp_4_des(g_des[3]), .grp_4_branch(g_br[3]), .grp_4_ime(g_ime[3]),
        .back_1_vld(b_vld[0]), .back_1_des(b_des[0]), .back_2_vld(b_vld[1]), .back_2_des(b_des[1]),
        .back_3_vld(b_vld[2]), .back_3_des(b_des[2]), .back_4_vld(b_vld[3]), .back_4_des(b_des[3]),
        .flush(flush),
        .iss_1_vld(o_vld[0]), .iss_1_op(o_op[0]), .iss_1_s1(o_s1[0]), .iss_1_s2(o_s2[0]),
        .iss_1_des(o_des[0]), .iss_1_branch(o_br[0]), .iss_1_ime(o_ime[0]),
        .iss_2_vld(o_vld[1]), .iss_2_op(o_op[1]), .iss_2_s1(o_s1[1]), .iss_2_s2(o_s2[1]),
        .iss_2_des(o_des[1]), .iss_2_branch(o_br[1]), .iss_2_ime(o_ime[1]),
        .iss_3_vld(o_vld[2]), .iss_3_op(o_op[2]), .iss_3_s1(o_s1[2]), .iss_3_s2(o_s2[2]),
        .iss_3_des(o_des[2]), .iss_3_branch(o_br[2]), .iss_3_ime(o_ime[2]),
        .iss_4_vld(o_vld[3]), .iss_4_op(o_op[3]), .iss_4_s1(o_s1[3]), .iss_4_s2(o_s2[3]),
        .iss_4_des(o_des[3]), .iss_4_branch(o_br[3]), .iss_4_ime(o_ime[3]),
        .stall_cnt(stall_cnt)
    );

    // Reference model state
    bit          m_pend [4];
    logic [3:0]  m_op   [4];
    logic [3:0]  m_s1   [4];
    logic [3:0]  m_s2   [4];
    logic [3:0]  m_des  [4];
    logic [3:0]  m_br   [4];
    logic [15:0] m_ime  [4];
    bit          m_busy [16];
    bit          e_vld  [4];
    logic [35:0] e_f    [4];
    int          e_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_vld();
        return {o_vld[3], o_vld[2], o_vld[1], o_vld[0]};
    endfunction

    // A slot may go if every earlier pending slot goes and none of its registers
    // is busy or written by an earlier pending slot; r0 never conflicts.
    function automatic void model_eval(output bit [3:0] go, output bit stuck);
        bit writes [16];
        bit bad;
        go    = 4'b0000;
        stuck = 1'b0;
        for (int r = 0; r < 16; r++) writes[r] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (m_pend[k] && !stuck) begin
                bad = 1'b0;
                if (m_s1[k] != 0 && (m_busy[m_s1[k]] || writes[m_s1[k]])) bad = 1'b1;
                if (m_op[k] != 4'b0100 && m_op[k] != 4'b0010 && m_s2[k] != 0 &&
                    (m_busy[m_s2[k]] || writes[m_s2[k]])) bad = 1'b1;
                if (m_des[k] != 0 && (m_busy[m_des[k]] || writes[m_des[k]])) bad = 1'b1;
                if (bad) stuck = 1'b1;
                else begin
                    go[k] = 1'b1;
                    writes[m_des[k]] = 1'b1;
                end
            end
        end
    endfunction

    // One clock: check ready before the edge, advance the model, compare after the edge
    task automatic step();
        bit [3:0] go;
        bit       stuck;
        bit       rdy;
        bit       anyp;
        #1;
        model_eval(go, stuck);
        rdy = !flush && !stuck;
        if (!rst) chk("grp_ready", grp_ready, rdy);
        anyp = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
        if (flush) go = 4'b0000;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_pend[k] = 1'b0; e_vld[k] = 1'b0; e_f[k] = '0;
            end
            for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
            e_stall = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                e_vld[k] = go[k];
                if (go[k]) e_f[k] = {m_op[k], m_s1[k], m_s2[k], m_des[k], m_br[k], m_ime[k]};
                if (go[k] || flush) m_pend[k] = 1'b0;
            end
            for (int i = 0; i < 4; i++) if (b_vld[i] && b_des[i] != 0) m_busy[b_des[i]] = 1'b0;
            for (int k = 0; k < 4; k++) if (go[k] && m_des[k] != 0) m_busy[m_des[k]] = 1'b1;
            if (anyp && go == 4'b0000 && !flush && e_stall < 65535) e_stall++;
            if (!flush && grp_valid && rdy) begin
                for (int k = 0; k < 4; k++) begin
                    m_pend[k] = g_vld[k]; m_op[k] = g_op[k]; m_s1[k] = g_s1[k];
                    m_s2[k] = g_s2[k]; m_des[k] = g_des[k]; m_br[k] = g_br[k]; m_ime[k] = g_ime[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("iss_vld lane%0d", k + 1), o_vld[k], e_vld[k]);
            chk($sformatf("iss_fields lane%0d", k + 1),
                {o_op[k], o_s1[k], o_s2[k], o_des[k], o_br[k], o_ime[k]}, e_f[k]);
        end
        chk("stall_cnt", stall_cnt, e_stall);
    endtask

    task automatic set_slot(input int k, input logic [3:0] op, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] des);
        g_vld[k] = 1'b1; g_op[k] = op; g_s1[k] = s1; g_s2[k] = s2; g_des[k] = des;
        g_br[k]  = 4'(k + des);
        g_ime[k] = 16'hA000 + 16'(k * 16 + des);
    endtask

    task automatic clear_grp();
        for (int k = 0; k < 4; k++) g_vld[k] = 1'b0;
    endtask

    task automatic accept_grp();
        grp_valid = 1'b1;
        step();
        grp_valid = 1'b0;
        clear_grp();
    endtask

    task automatic retire(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                          input logic [3:0] d4);
        b_des[0] = d1; b_des[1] = d2; b_des[2] = d3; b_des[3] = d4;
        for (int i = 0; i < 4; i++) b_vld[i] = (b_des[i] != 4'd0);
        step();
        for (int i = 0; i < 4; i++) b_vld[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; grp_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g_vld[k] = 0; g_op[k] = 0; g_s1[k] = 0; g_s2[k] = 0; g_des[k] = 0; g_br[k] = 0;
            g_ime[k] = 0; b_vld[k] = 0; b_des[k] = 0;
        end
        step();
        rst = 1'b0;
        chk("reset iss_vld", dut_vld(), 4'b0000);
        chk("reset stall_cnt", stall_cnt, 16'd0);
        #1;
        chk("reset grp_ready", grp_ready, 1'b1);

        // Independent group
        set_slot(0, 4'h0, 4'd2, 4'd3, 4'd1);
        set_slot(1, 4'h1, 4'd5, 4'd6, 4'd4);
        set_slot(2, 4'h3, 4'd8, 4'd9, 4'd7);
        set_slot(3, 4'h5, 4'd11, 4'd12, 4'd10);
        accept_grp();
        step();
        chk("indep all lanes", dut_vld(), 4'b1111);
        chk("indep lane4 des", o_des[3], 4'd10);
        retire(4'd1, 4'd4, 4'd7, 4'd10);

        // Intra-group RAW stalls the whole tail
        set_slot(0, 4'h0, 4'd1, 4'd2, 4'd5);
        set_slot(1, 4'h0, 4'd5, 4'd3, 4'd6);
        set_slot(2, 4'h0, 4'd1, 4'd2, 4'd13);
        set_slot(3, 4'h0, 4'd3, 4'd4, 4'd14);
        accept_grp();
        step();
        chk("raw lane1 only", dut_vld(), 4'b0001);
        step();
        chk("raw stalled", dut_vld(), 4'b0000);
        chk("raw stall 1", stall_cnt, 16'd1);
        retire(4'd5, 4'd0, 4'd0, 4'd0);
        chk("raw no bypass", dut_vld(), 4'b0000);
        chk("raw stall 2", stall_cnt, 16'd2);
        step();
        chk("raw release", dut_vld(), 4'b1110);
        retire(4'd0, 4'd6, 4'd13, 4'd14);

        // WAW against a busy dest
        set_slot(0, 4'h0, 4'd1, 4'd2, 4'd7);
        accept_grp();
        step();
        set_slot(0, 4'h7, 4'd3, 4'd4, 4'd7);
        accept_grp();
        step();
        chk("waw stall 3", stall_cnt, 16'd3);
        step();
        chk("waw stall 4", stall_cnt, 16'd4);
        retire(4'd7, 4'd0, 4'd0, 4'd0);
        chk("waw stall 5", stall_cnt, 16'd5);
        step();
        chk("waw issues", dut_vld(), 4'b0001);
        chk("waw stall holds", stall_cnt, 16'd5);
        retire(4'd7, 4'd0, 4'd0, 4'd0);

        // Single-source ops ignore a busy s2; a two-source op does not
        set_slot(0, 4'h0, 4'd1, 4'd2, 4'd9);
        accept_grp();
        step();
        set_slot(0, 4'b0100, 4'd1, 4'd9, 4'd3);
        set_slot(1, 4'b0010, 4'd2, 4'd9, 4'd12);
        set_slot(2, 4'b0001, 4'd1, 4'd9, 4'd15);
        accept_grp();
        step();
        chk("one-src issue", dut_vld(), 4'b0011);
        retire(4'd9, 4'd0, 4'd0, 4'd0);
        step();
        chk("two-src after retire", dut_vld(), 4'b0100);
        retire(4'd3, 4'd12, 4'd15, 4'd0);

        // r0 never hazards or becomes busy
        set_slot(0, 4'h0, 4'd0, 4'd0, 4'd0);
        set_slot(1, 4'h0, 4'd0, 4'd0, 4'd0);
        accept_grp();
        step();
        chk("r0 issue", dut_vld(), 4'b0011);
        set_slot(0, 4'h0, 4'd0, 4'd0, 4'd0);
        accept_grp();
        step();
        chk("r0 not busy", dut_vld(), 4'b0001);

        // Flush a stalled group; busy survives
        set_slot(0, 4'h0, 4'd1, 4'd2, 4'd5);
        accept_grp();
        step();
        set_slot(0, 4'h0, 4'd5, 4'd1, 4'd6);
        set_slot(1, 4'h0, 4'd1, 4'd2, 4'd8);
        accept_grp();
        step();
        flush = 1'b1;
        #1;
        chk("flush ready low", grp_ready, 1'b0);
        step();
        flush = 1'b0;
        chk("flush iss_vld", dut_vld(), 4'b0000);
        #1;
        chk("post-flush ready", grp_ready, 1'b1);
        set_slot(0, 4'h0, 4'd5, 4'd1, 4'd10);
        accept_grp();
        step();
        chk("busy kept by flush", dut_vld(), 4'b0000);

        // Reset mid-group clears pending and busy
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst iss_vld", dut_vld(), 4'b0000);
        chk("rst stall_cnt", stall_cnt, 16'd0);
        #1;
        chk("post-rst ready", grp_ready, 1'b1);
        set_slot(0, 4'h0, 4'd5, 4'd1, 4'd10);
        accept_grp();
        step();
        chk("busy cleared by rst", dut_vld(), 4'b0001);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
